// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch state encoding and word geometry.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [INSTR_W-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures ir into the IF/ID register,
// handles stalls, redirects, end-of-program sentinel, drain and halt.
module instr_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] HALT_WORD    = DEF_HALT_WORD,
    parameter int unsigned        MEM_WORDS    = 8192,
    parameter int unsigned        DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [INSTR_W-1:0] pc_address,
    input  logic [INSTR_W-1:0] ir,
    input  logic               id_ready,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc,
    output logic               halted,
    output logic               fault
);

    // One extra bit so the byte limit itself is representable.
    localparam logic [INSTR_W:0] PC_LIMIT   = 33'(MEM_WORDS) * 33'(WORD_BYTES);
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [INSTR_W-1:0] PC_STEP  = 32'(WORD_BYTES);

    function automatic logic pc_bad(input logic [INSTR_W-1:0] pc);
        return (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);
    endfunction

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] ifpc_q, ifpc_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;
    logic [3:0]         cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (valid_q && !id_ready) begin
                    // stall: everything holds
                end else if (pc_bad(pc_q)) begin
                    fault_d  = 1'b1;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = HALTED;
                end else if (ir == HALT_WORD) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    instr_d = ir;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    // The sentinel was fetched down a wrong path.
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else begin
                    if (id_ready) valid_d = 1'b0;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == DRAIN_LAST) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end
                end
            end
            HALTED: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            ifpc_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc_address = pc_q;
    assign if_valid   = valid_q;
    assign if_instr   = instr_q;
    assign if_pc      = ifpc_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule
